// File: rtl/post_spike_aer_encoder.sv
// ============================================================================
//  Module   : post_spike_aer_encoder
//  Purpose  : Serializes 4-bit post-neuron spike vectors into AER addresses and
//             end-of-timestep markers, buffered in a first-word-fall-through FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module post_spike_aer_encoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int GROUP_W    = 6,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evt_valid,
  input  logic [3:0]                   evt_mask,
  input  logic [GROUP_W-1:0]           evt_group,
  input  logic                         tstep_in,
  output logic                         in_ready,
  output logic                         aer_valid,
  input  logic                         aer_ready,
  output logic [GROUP_W+2:0]           aer_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [CNT_W-1:0]             spike_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = GROUP_W + 3;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  function automatic logic [2:0] popcnt4(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  // Pending event and marker state
  logic [3:0]           pend_mask;
  logic [GROUP_W-1:0]   pend_group;
  logic                 marker_pend;
  logic [GROUP_W+1:0]   tstep_cnt;

  // FIFO storage and pointers
  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          level;

  // Combinational control
  logic                 pop;
  logic                 push_ok;
  logic                 push;
  logic [DW-1:0]        push_data;
  logic                 spike_push;
  logic                 marker_push;
  logic [1:0]           sel_idx;
  logic [3:0]           pend_next;
  logic                 capture;
  logic                 evt_drop;
  logic                 mk_drop;
  logic [2:0]           drop_inc;
  logic [CNT_W:0]       drop_sum;

  assign in_ready   = (pend_mask == 4'd0) && !marker_pend;
  assign aer_valid  = (level != '0);
  assign aer_data   = aer_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  assign pop     = aer_valid && aer_ready;
  assign push_ok = (level != C_DEPTH) || pop;

  always_comb begin
    sel_idx = 2'd3;
    if (pend_mask[0])      sel_idx = 2'd0;
    else if (pend_mask[1]) sel_idx = 2'd1;
    else if (pend_mask[2]) sel_idx = 2'd2;
  end

  // Spikes of a pending event always precede a queued marker.
  always_comb begin
    spike_push  = 1'b0;
    marker_push = 1'b0;
    push_data   = '0;
    pend_next   = pend_mask;
    if (pend_mask != 4'd0) begin
      push_data = {1'b0, pend_group, sel_idx};
      if (push_ok) begin
        spike_push = 1'b1;
        pend_next  = pend_mask & ~(4'b0001 << sel_idx);
      end
    end else if (marker_pend) begin
      push_data = {1'b1, tstep_cnt};
      if (push_ok) begin
        marker_push = 1'b1;
      end
    end
  end

  assign push = spike_push || marker_push;

  assign capture  = evt_valid && in_ready && (evt_mask != 4'd0);
  assign evt_drop = evt_valid && !in_ready && (evt_mask != 4'd0);
  assign mk_drop  = tstep_in && marker_pend;
  assign drop_inc = (evt_drop ? popcnt4(evt_mask) : 3'd0) + {2'b00, mk_drop};
  assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-2){1'b0}}, drop_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mask   <= 4'd0;
      pend_group  <= '0;
      marker_pend <= 1'b0;
      tstep_cnt   <= '0;
    end else begin
      if (capture) begin
        pend_mask  <= evt_mask;
        pend_group <= evt_group;
      end else begin
        pend_mask  <= pend_next;
      end
      if (marker_push) begin
        marker_pend <= 1'b0;
        tstep_cnt   <= tstep_cnt + 1'b1;
      end else if (tstep_in) begin
        marker_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      spike_cnt <= '0;
    end else begin
      if (evt_drop || mk_drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
      if (marker_push) begin
        spike_cnt <= '0;
      end else if (spike_push && !(&spike_cnt)) begin
        spike_cnt <= spike_cnt + 1'b1;
      end
    end
  end

  // Storage is not reset; the head output is gated by the occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_post_spike_aer_encoder.sv
// ============================================================================
//  Module   : tb_post_spike_aer_encoder
//  Purpose  : Directed and randomized checks of post_spike_aer_encoder against
//             a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_post_spike_aer_encoder;

  localparam int DEPTH = 16;
  localparam int CMAX  = 65535;

  logic       clk = 1'b0;
  logic       rst;
  logic       evt_valid;
  logic [3:0] evt_mask;
  logic [5:0] evt_group;
  logic       tstep_in;
  logic       in_ready;
  logic       aer_valid;
  logic       aer_ready;
  logic [8:0] aer_data;
  logic [4:0] fifo_level;
  logic       overflow;
  logic [15:0] drop_cnt;
  logic [15:0] spike_cnt;

  post_spike_aer_encoder #(.FIFO_DEPTH(DEPTH), .GROUP_W(6), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .evt_valid  (evt_valid),
    .evt_mask   (evt_mask),
    .evt_group  (evt_group),
    .tstep_in   (tstep_in),
    .in_ready   (in_ready),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .aer_data   (aer_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .spike_cnt  (spike_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending spikes and FIFO contents as queues of words
  int m_pend[$];
  int m_fifo[$];
  bit m_mpend;
  int m_tstep;
  bit m_ovf;
  int m_drop;
  int m_spike;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    return (m_pend.size() == 0) && !m_mpend;
  endfunction

  task automatic model_step(input bit ev, input logic [3:0] mask, input int grp,
                            input bit ts, input bit rdy, input bit r);
    bit old_pend_empty, old_mpend, rdy_in, pop, push_ok;
    int drops;
    if (r) begin
      m_pend.delete();
      m_fifo.delete();
      m_mpend = 0; m_tstep = 0; m_ovf = 0; m_drop = 0; m_spike = 0;
      return;
    end
    old_pend_empty = (m_pend.size() == 0);
    old_mpend      = m_mpend;
    rdy_in         = old_pend_empty && !old_mpend;
    pop            = (m_fifo.size() > 0) && rdy;
    push_ok        = (m_fifo.size() < DEPTH) || pop;
    if (pop) void'(m_fifo.pop_front());
    if (!old_pend_empty) begin
      if (push_ok) begin
        m_fifo.push_back(m_pend.pop_front());
        if (m_spike < CMAX) m_spike++;
      end
    end else if (old_mpend && push_ok) begin
      m_fifo.push_back(256 + (m_tstep % 256));
      m_tstep = (m_tstep + 1) % 256;
      m_spike = 0;
      m_mpend = 0;
    end
    drops = 0;
    if (ev && mask != 4'd0) begin
      if (rdy_in) begin
        for (int i = 0; i < 4; i++)
          if (mask[i]) m_pend.push_back(grp * 4 + i);
      end else begin
        m_ovf = 1;
        drops += $countones(mask);
      end
    end
    if (ts) begin
      if (old_mpend) begin
        m_ovf = 1;
        drops++;
      end else begin
        m_mpend = 1;
      end
    end
    m_drop = (m_drop + drops > CMAX) ? CMAX : m_drop + drops;
  endtask

  task automatic compare_all();
    check_eq("in_ready",   {31'd0, in_ready},   {31'd0, m_in_ready()});
    check_eq("aer_valid",  {31'd0, aer_valid},  (m_fifo.size() != 0) ? 1 : 0);
    check_eq("aer_data",   {23'd0, aer_data},   (m_fifo.size() != 0) ? m_fifo[0] : 0);
    check_eq("fifo_level", {27'd0, fifo_level}, m_fifo.size());
    check_eq("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
    check_eq("drop_cnt",   {16'd0, drop_cnt},   m_drop);
    check_eq("spike_cnt",  {16'd0, spike_cnt},  m_spike);
  endtask

  task automatic step(input bit ev, input logic [3:0] mask, input logic [5:0] grp,
                      input bit ts, input bit rdy, input bit r);
    evt_valid = ev; evt_mask = mask; evt_group = grp;
    tstep_in = ts; aer_ready = rdy; rst = r;
    model_step(ev, mask, int'(grp), ts, rdy, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 4'd0, 6'd0, 0, rdy, 0);
  endtask

  initial begin
    int sent;
    int markers;
    int rdy_pct;
    evt_valid = 0; evt_mask = 0; evt_group = 0; tstep_in = 0; aer_ready = 0; rst = 1;

    // Reset state
    step(0, 4'd0, 6'd0, 0, 0, 1);
    step(0, 4'd0, 6'd0, 0, 0, 1);
    check_eq("reset_in_ready", {31'd0, in_ready}, 1);
    check_eq("reset_level", {27'd0, fifo_level}, 0);

    // Three spikes from one event, streamed out one per cycle
    step(1, 4'b1011, 6'h05, 0, 1, 0);
    check_eq("t1_busy0", {31'd0, in_ready}, 0);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t1_d0", {23'd0, aer_data}, 32'h014);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t1_d1", {23'd0, aer_data}, 32'h015);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t1_d2", {23'd0, aer_data}, 32'h017);
    check_eq("t1_ready", {31'd0, in_ready}, 1);
    idle(2, 1);

    // Fill FIFO with a stalled consumer, then drop an event
    step(0, 4'd0, 6'd0, 0, 0, 1);
    sent = 0;
    for (int c = 0; c < 100 && sent < 17; c++) begin
      if (m_in_ready()) begin
        step(1, 4'b0001 << (sent % 4), 6'(sent), 0, 0, 0);
        sent++;
      end else begin
        idle(1, 0);
      end
    end
    idle(3, 0);
    check_eq("t2_level", {27'd0, fifo_level}, 16);
    check_eq("t2_stall", {31'd0, in_ready}, 0);
    step(1, 4'b0100, 6'h3F, 0, 0, 0);
    check_eq("t2_ovf", {31'd0, overflow}, 1);
    check_eq("t2_drop", {16'd0, drop_cnt}, 1);

    // Simultaneous push and pop while full
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t3_level", {27'd0, fifo_level}, 16);
    idle(20, 1);

    // Event with a same-cycle timestep marker
    step(0, 4'd0, 6'd0, 0, 0, 1);
    step(1, 4'b0011, 6'h02, 1, 1, 0);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t4_s0", {23'd0, aer_data}, 32'h008);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t4_s1", {23'd0, aer_data}, 32'h009);
    check_eq("t4_cnt2", {16'd0, spike_cnt}, 2);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t4_m0", {23'd0, aer_data}, 32'h100);
    check_eq("t4_cnt0", {16'd0, spike_cnt}, 0);
    step(0, 4'd0, 6'd0, 1, 1, 0);
    step(0, 4'd0, 6'd0, 0, 1, 0);
    check_eq("t4_m1", {23'd0, aer_data}, 32'h101);

    // Two markers requested while busy: second dropped
    step(0, 4'd0, 6'd0, 0, 0, 1);
    step(1, 4'b1111, 6'h07, 0, 1, 0);
    step(0, 4'd0, 6'd0, 1, 1, 0);
    step(0, 4'd0, 6'd0, 1, 1, 0);
    check_eq("t5_drop", {16'd0, drop_cnt}, 1);
    markers = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 1);
      if (aer_valid && aer_data[8]) markers++;
    end
    check_eq("t5_markers", markers, 1);

    // Reset mid-burst
    step(0, 4'd0, 6'd0, 0, 0, 1);
    step(1, 4'b1111, 6'h01, 0, 0, 0);
    idle(4, 0);
    step(1, 4'b0001, 6'h02, 0, 0, 0);
    idle(1, 0);
    check_eq("t6_level5", {27'd0, fifo_level}, 5);
    step(1, 4'b1111, 6'h03, 1, 0, 0);
    step(0, 4'd0, 6'd0, 0, 0, 1);
    check_eq("t6_valid", {31'd0, aer_valid}, 0);
    check_eq("t6_data", {23'd0, aer_data}, 0);
    check_eq("t6_level", {27'd0, fifo_level}, 0);
    check_eq("t6_ready", {31'd0, in_ready}, 1);

    // Randomized traffic with varying consumer throughput
    rdy_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(10, 100);
      step(($urandom % 3) == 0, 4'($urandom), 6'($urandom), ($urandom % 12) == 0,
           ($urandom_range(1, 100) <= rdy_pct), ($urandom % 1500) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
